// File: rtl/writeback_queue.sv
// Writeback queue: buffers register-file writes until the write port is free.
// Optional decode-stage forwarding is built when WBQ_FORWARD_EN is defined.
module writeback_queue #(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [4:0]               in_reg,
  input  logic [31:0]              in_data,
  input  logic                     drain_en,
  output logic                     RegWrite,
  output logic [4:0]               write_reg,
  output logic [31:0]              write_data,
  input  logic [4:0]               read_reg1,
  input  logic [4:0]               read_reg2,
  output logic                     fwd_hit1,
  output logic                     fwd_hit2,
  output logic [31:0]              fwd_data1,
  output logic [31:0]              fwd_data2,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     zero_drop
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_C = (AW+1)'(DEPTH);

  logic [4:0]    reg_mem [DEPTH];
  logic [31:0]   data_mem [DEPTH];
  logic [AW-1:0] head_q, head_d;
  logic [AW-1:0] tail_q, tail_d;
  logic [AW:0]   count_q, count_d;
  logic          regwrite_q;
  logic [4:0]    write_reg_q;
  logic [31:0]   write_data_q;
  logic          zero_drop_q;
  logic          push_s, pop_s, drop_s;

  assign in_ready   = (count_q < FULL_C);
  assign push_s     = in_valid && in_ready && (in_reg != 5'd0);
  assign drop_s     = in_valid && in_ready && (in_reg == 5'd0);
  assign pop_s      = drain_en && (count_q != {(AW+1){1'b0}});
  assign RegWrite   = regwrite_q;
  assign write_reg  = write_reg_q;
  assign write_data = write_data_q;
  assign count      = count_q;
  assign zero_drop  = zero_drop_q;

  // Next-state pointers and occupancy
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (pop_s) begin
      head_d = head_q + {{(AW-1){1'b0}}, 1'b1};
    end else begin
      head_d = head_q;
    end
    if (push_s) begin
      tail_d = tail_q + {{(AW-1){1'b0}}, 1'b1};
    end else begin
      tail_d = tail_q;
    end
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + {{AW{1'b0}}, 1'b1};
      2'b01:   count_d = count_q - {{AW{1'b0}}, 1'b1};
      default: count_d = count_q;
    endcase
  end

  // Control state and output stage
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head_q       <= {AW{1'b0}};
      tail_q       <= {AW{1'b0}};
      count_q      <= {(AW+1){1'b0}};
      regwrite_q   <= 1'b0;
      write_reg_q  <= 5'd0;
      write_data_q <= 32'd0;
      zero_drop_q  <= 1'b0;
    end else begin
      head_q      <= head_d;
      tail_q      <= tail_d;
      count_q     <= count_d;
      regwrite_q  <= pop_s;
      zero_drop_q <= drop_s;
      if (pop_s) begin
        write_reg_q  <= reg_mem[head_q];
        write_data_q <= data_mem[head_q];
      end
    end
  end

  // Entry storage; occupancy alone decides validity, so no reset needed
  always_ff @(posedge clk) begin
    if (push_s) begin
      reg_mem[tail_q]  <= in_reg;
      data_mem[tail_q] <= in_data;
    end
  end

`ifdef WBQ_FORWARD_EN
  // Scan oldest to youngest so the last match (youngest) wins.
  function automatic logic [32:0] lookup(input logic [4:0] rr);
    logic [32:0]   res;
    logic [AW-1:0] idx;
    res = 33'd0;
    if (rr != 5'd0) begin
      if (regwrite_q && (write_reg_q == rr)) begin
        res = {1'b1, write_data_q};
      end
      for (int i = 0; i < DEPTH; i++) begin
        idx = head_q + AW'(i);
        if (((AW+1)'(i) < count_q) && (reg_mem[idx] == rr)) begin
          res = {1'b1, data_mem[idx]};
        end
      end
    end
    return res;
  endfunction

  // Combinational forwarding lookup for both read ports
  always_comb begin
    {fwd_hit1, fwd_data1} = lookup(read_reg1);
    {fwd_hit2, fwd_data2} = lookup(read_reg2);
  end
`else
  assign fwd_hit1  = 1'b0;
  assign fwd_hit2  = 1'b0;
  assign fwd_data1 = 32'd0;
  assign fwd_data2 = 32'd0;
`endif

endmodule

// File: tb/tb_writeback_queue.sv
// Scoreboard bench for writeback_queue; forwarding expectations follow WBQ_FORWARD_EN.
module tb_writeback_queue;

`ifdef WBQ_FORWARD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_reg;
  logic [31:0] in_data;
  logic        drain_en;
  logic        RegWrite;
  logic [4:0]  write_reg;
  logic [31:0] write_data;
  logic [4:0]  read_reg1, read_reg2;
  logic        fwd_hit1, fwd_hit2;
  logic [31:0] fwd_data1, fwd_data2;
  logic [2:0]  count;
  logic        zero_drop;

  int checks = 0;
  int failures = 0;
  int rw_count = 0;
  logic [36:0] sb[$];

  writeback_queue #(.DEPTH(4)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_reg(in_reg), .in_data(in_data), .drain_en(drain_en),
    .RegWrite(RegWrite), .write_reg(write_reg), .write_data(write_data),
    .read_reg1(read_reg1), .read_reg2(read_reg2),
    .fwd_hit1(fwd_hit1), .fwd_hit2(fwd_hit2),
    .fwd_data1(fwd_data1), .fwd_data2(fwd_data2),
    .count(count), .zero_drop(zero_drop)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%h expected=0x%h", name, act, exp);
    end
  endtask

  // Monitor: every register-file write must match the oldest expected entry
  always @(negedge clk) begin
    if (!reset && RegWrite) begin
      rw_count++;
      if (sb.size() == 0) begin
        chk("unexpected_write", {27'd0, write_reg}, 32'd0);
      end else begin
        logic [36:0] e;
        e = sb.pop_front();
        chk("write_reg", {27'd0, write_reg}, {27'd0, e[36:32]});
        chk("write_data", write_data, e[31:0]);
      end
    end
  end

  task automatic offer(input logic [4:0] r, input logic [31:0] d, output bit acc);
    in_valid = 1'b1; in_reg = r; in_data = d;
    #1;
    acc = in_ready;
    if (acc && r != 5'd0) sb.push_back({r, d});
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_empty();
    bit done;
    done = 1'b0;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk);
      if (count == 3'd0) done = 1'b1;
    end
    if (!done) chk("drain_timeout", {29'd0, count}, 32'd0);
  endtask

  initial begin
    bit acc;
    int snap;
    reset = 1'b1; in_valid = 1'b0; in_reg = 5'd0; in_data = 32'd0;
    drain_en = 1'b0; read_reg1 = 5'd0; read_reg2 = 5'd0;
    #1;
    chk("rst_count", {29'd0, count}, 32'd0);
    chk("rst_regwrite", {31'd0, RegWrite}, 32'd0);
    chk("rst_write_data", write_data, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    @(negedge clk); @(negedge clk);
    reset = 1'b0;

    // Single write, one-cycle drain latency
    drain_en = 1'b1;
    offer(5'd5, 32'hDEADBEEF, acc);
    chk("single_count1", {29'd0, count}, 32'd1);
    chk("single_rw_early", {31'd0, RegWrite}, 32'd0);
    @(negedge clk);
    chk("single_rw", {31'd0, RegWrite}, 32'd1);
    chk("single_reg", {27'd0, write_reg}, 32'd5);
    chk("single_count0", {29'd0, count}, 32'd0);
    @(negedge clk);
    chk("single_rw_pulse", {31'd0, RegWrite}, 32'd0);
    chk("single_hold", write_data, 32'hDEADBEEF);

    // Fill to full, reject fifth, then drain in order
    drain_en = 1'b0;
    for (int i = 1; i <= 4; i++) offer(5'(i), 32'h100 + 32'(i), acc);
    chk("full_count", {29'd0, count}, 32'd4);
    chk("full_ready", {31'd0, in_ready}, 32'd0);
    offer(5'd9, 32'h999, acc);
    chk("full_reject", {31'd0, acc}, 32'd0);
    chk("full_count_hold", {29'd0, count}, 32'd4);
    drain_en = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      chk("drain_rw", {31'd0, RegWrite}, 32'd1);
      chk("drain_order", {27'd0, write_reg}, 32'(i));
    end
    @(negedge clk);

    // Writes to $zero are dropped with a one-cycle pulse
    snap = rw_count;
    offer(5'd0, 32'h1234, acc);
    chk("zero_pulse", {31'd0, zero_drop}, 32'd1);
    chk("zero_count", {29'd0, count}, 32'd0);
    @(negedge clk);
    chk("zero_pulse_end", {31'd0, zero_drop}, 32'd0);
    @(negedge clk);
    chk("zero_no_write", 32'(rw_count), 32'(snap));

    // Forwarding: youngest wins, same-edge push invisible, output stage searched
    drain_en = 1'b0;
    offer(5'd7, 32'hA, acc);
    offer(5'd7, 32'hB, acc);
    read_reg1 = 5'd7; read_reg2 = 5'd0;
    #1;
    chk("fwd_hit1", {31'd0, fwd_hit1}, {31'd0, FWD});
    chk("fwd_data1_young", fwd_data1, FWD ? 32'hB : 32'd0);
    chk("fwd_hit2_zero", {31'd0, fwd_hit2}, 32'd0);
    read_reg1 = 5'd9;
    in_valid = 1'b1; in_reg = 5'd9; in_data = 32'hC;
    #1;
    chk("fwd_same_edge", {31'd0, fwd_hit1}, 32'd0);
    sb.push_back({5'd9, 32'hC});
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    chk("fwd_after_edge", fwd_data1, FWD ? 32'hC : 32'd0);
    drain_en = 1'b1;
    @(negedge clk);
    @(negedge clk);
    read_reg2 = 5'd7;
    #1;
    chk("fwd_outstage_hit", {31'd0, fwd_hit2}, {31'd0, FWD});
    chk("fwd_outstage_data", fwd_data2, FWD ? 32'hB : 32'd0);
    read_reg2 = 5'd0;
    wait_empty();
    @(negedge clk);

    // Random drain across pointer wrap
    for (int i = 0; i < 10; i++) begin
      drain_en = 1'($urandom_range(0, 1));
      offer(5'(10 + i), 32'h1000_0000 + 32'(i), acc);
    end
    drain_en = 1'b1;
    wait_empty();
    @(negedge clk); @(negedge clk);
    chk("wrap_sb_empty", 32'(sb.size()), 32'd0);

    // Reset with three pending entries and a live output stage
    drain_en = 1'b0;
    for (int i = 0; i < 4; i++) offer(5'(20 + i), 32'h2000 + 32'(i), acc);
    drain_en = 1'b1;
    @(negedge clk);
    drain_en = 1'b0;
    chk("pre_rst_count", {29'd0, count}, 32'd3);
    chk("pre_rst_rw", {31'd0, RegWrite}, 32'd1);
    read_reg1 = 5'd21;
    #2 reset = 1'b1;
    #1;
    chk("rst_mid_count", {29'd0, count}, 32'd0);
    chk("rst_mid_rw", {31'd0, RegWrite}, 32'd0);
    chk("rst_mid_fwd", {31'd0, fwd_hit1}, 32'd0);
    sb.delete();
    @(negedge clk);
    reset = 1'b0;
    snap = rw_count;
    drain_en = 1'b1;
    repeat (3) @(negedge clk);
    chk("no_stale_drain", 32'(rw_count), 32'(snap));
    offer(5'd3, 32'hCAFE0003, acc);
    wait_empty();
    @(negedge clk); @(negedge clk);
    chk("post_rst_sb_empty", 32'(sb.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/writeback_queue.md
WRITEBACK_QUEUE -- requirements
Module: writeback_queue

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4, power of two ≥2: number of pending-write entries.
REQ-002 The block SHALL have port clk  input  1  rising-edge clock.
REQ-003 The block SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 The block SHALL have port in_valid  input  1  producer offers a register write.
REQ-005 The block SHALL have port in_ready  output  1  queue accepts the offer this cycle.
REQ-006 The block SHALL have port in_reg  input  5  destination register number.
REQ-007 The block SHALL have port in_data  input  32  destination write value.
REQ-008 The block SHALL have port drain_en  input  1  register-file write port free this cycle.
REQ-009 The block SHALL have port RegWrite  output  1  register-file write strobe.
REQ-010 The block SHALL have port write_reg  output  5  register-file write register number.
REQ-011 The block SHALL have port write_data  output  32  register-file write data.
REQ-012 The block SHALL have ports read_reg1, read_reg2  input  5 each  register numbers being read by the decode stage.
REQ-013 The block SHALL have ports fwd_hit1, fwd_hit2  output  1 each  a pending write targets the read register.
REQ-014 The block SHALL have ports fwd_data1, fwd_data2  output  32 each  the pending value to forward.
REQ-015 The block SHALL have port count  output  log2(DEPTH)+1  number of occupied entries.
REQ-016 The block SHALL have port zero_drop  output  1  one-cycle pulse after a discarded $zero write.

Function
REQ-017 The block SHALL drive in_ready = (count < DEPTH), combinationally; no same-cycle pass-through when full.
REQ-018 The block SHALL complete a handshake on an edge where in_valid && in_ready.
REQ-019 On a handshake with in_reg != 0, the block SHALL store {in_reg, in_data} at the tail and advance the tail pointer modulo DEPTH.
REQ-020 On a handshake with in_reg == 0, the block SHALL discard the entry, leave count unchanged, and assert zero_drop for exactly the following cycle.
REQ-021 On an edge where drain_en && count != 0, the block SHALL pop the head and register it to write_reg/write_data with RegWrite = 1 for exactly one cycle.
REQ-022 On any other edge, the block SHALL drive RegWrite = 0 and hold write_reg/write_data at their previous values.
REQ-023 Latency SHALL be: an entry accepted at edge N pops earliest at edge N+1 and reaches the register file at edge N+2.
REQ-024 On a simultaneous push and pop (count < DEPTH, count != 0), count SHALL be unchanged and both pointers SHALL advance.
REQ-025 Entries SHALL drain in strict FIFO order; pointers SHALL wrap modulo DEPTH with no lost or duplicated entry.
REQ-026 Forwarding lookup SHALL search all occupied entries plus the output stage while RegWrite = 1; the youngest match wins; the output stage is oldest.
REQ-027 fwd_hitN and fwd_dataN SHALL be combinational; with no match or read_regN == 0, they SHALL be 0 and 0.
REQ-028 A write accepted on the same edge as a lookup SHALL NOT be visible to that cycle's lookup.

Reset
REQ-029 Asserting reset SHALL immediately clear the head and tail pointers, count, RegWrite, write_reg, write_data and zero_drop to 0, independent of clk.
REQ-030 Reset mid-operation SHALL discard all pending entries; entry storage need not be cleared, and no stale entry SHALL forward or drain.

Configuration
REQ-031 With macro WBQ_FORWARD_EN defined, the block SHALL implement REQ-026 to REQ-028.
REQ-032 Without WBQ_FORWARD_EN, fwd_hit1/2 and fwd_data1/2 SHALL be tied to 0 and no lookup comparators SHALL be built.

Verification
REQ-033 Single write: reset, then push {reg 5, 0xDEADBEEF} with drain_en = 1 -> RegWrite = 1 exactly one cycle later with write_reg = 5, write_data = 0xDEADBEEF; count returns to 0.
REQ-034 Fill/full: drain_en = 0, push regs 1..4 -> count = 4, in_ready = 0; a fifth offer is not accepted; then drain_en = 1 -> writes 1,2,3,4 in order on consecutive cycles.
REQ-035 Zero register: push {reg 0, 0x1234} -> zero_drop pulses one cycle, count stays 0, RegWrite is never asserted.
REQ-036 Forwarding (WBQ_FORWARD_EN): drain_en = 0, push {7, 0xA} then {7, 0xB}, read_reg1 = 7 -> fwd_hit1 = 1, fwd_data1 = 0xB; read_reg2 = 0 -> fwd_hit2 = 0.
REQ-037 Wrap and reset: 10 push/pop cycles with random drain_en -> FIFO order preserved across wrap; assert reset with count = 3 -> count = 0, RegWrite = 0, fwd_hit1 = 0 immediately.
